// File: rtl/mult_pkg.sv
// Shared definitions for the multiplier / product-accumulator MAC path.
package mult_pkg;

  localparam int unsigned PROD_W = 64;
  localparam int unsigned LIM_W  = 256;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } acc_state_t;

  // Signed limits of a w-bit value; callers truncate to w bits (w <= LIM_W).
  function automatic logic [LIM_W-1:0] signed_max(input int unsigned w);
    return (LIM_W'(1) << (w - 1)) - LIM_W'(1);
  endfunction

  function automatic logic [LIM_W-1:0] signed_min(input int unsigned w);
    return LIM_W'(1) << (w - 1);
  endfunction

endpackage

// File: rtl/sat_add.sv
// Combinational ACC_W-bit signed add of a sign-extended product, with overflow detect.
// Clamping on overflow is compiled in with PRODUCT_ACC_SAT_EN; otherwise the sum wraps.
module sat_add
  import mult_pkg::*;
#(
  parameter int unsigned ACC_W = 72
) (
  input  logic [ACC_W-1:0]  sum,
  input  logic [PROD_W-1:0] addend,
  output logic [ACC_W-1:0]  sum_c,
  output logic              ovf_c
);

  localparam int unsigned EXT_W = ACC_W + 1 - PROD_W;

`ifdef PRODUCT_ACC_SAT_EN
  localparam logic [ACC_W-1:0] SMAX = ACC_W'(signed_max(ACC_W));
  localparam logic [ACC_W-1:0] SMIN = ACC_W'(signed_min(ACC_W));
`endif

  logic [ACC_W:0] wide;

  // One guard bit: overflow whenever the top two bits of the wide result disagree.
  always_comb begin
    wide  = {sum[ACC_W-1], sum} + {{EXT_W{addend[PROD_W-1]}}, addend};
    ovf_c = wide[ACC_W] ^ wide[ACC_W-1];
`ifdef PRODUCT_ACC_SAT_EN
    if (ovf_c) begin
      sum_c = wide[ACC_W] ? SMIN : SMAX;
    end else begin
      sum_c = wide[ACC_W-1:0];
    end
`else
    sum_c = wide[ACC_W-1:0];
`endif
  end

endmodule

// File: rtl/product_accumulator.sv
// Sums a programmed number of signed 64-bit products into a wide accumulator.
// Build option PRODUCT_ACC_SAT_EN selects saturating instead of wrapping sums.
module product_accumulator
  import mult_pkg::*;
#(
  parameter int unsigned ACC_W = 72,
  parameter int unsigned LEN_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic [PROD_W-1:0] prod_in,
  input  logic              prod_valid,
  output logic [ACC_W-1:0]  acc_out,
  output logic              acc_valid,
  output logic              busy,
  output logic              overflow
);

  acc_state_t       state;
  logic [LEN_W-1:0] cnt;
  logic [ACC_W-1:0] sum;
  logic [ACC_W-1:0] add_sum_c;
  logic             add_ovf_c;

  sat_add #(.ACC_W(ACC_W)) u_sat_add (
    .sum    (sum),
    .addend (prod_in),
    .sum_c  (add_sum_c),
    .ovf_c  (add_ovf_c)
  );

  // Result is published on entry to DONE so acc_valid is high for the DONE cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      sum       <= '0;
      acc_out   <= '0;
      acc_valid <= 1'b0;
      busy      <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      acc_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            sum      <= '0;
            overflow <= 1'b0;
            busy     <= 1'b1;
            if (len != '0) begin
              cnt   <= len;
              state <= ACCUM;
            end else begin
              acc_out   <= '0;
              acc_valid <= 1'b1;
              state     <= DONE;
            end
          end
        end
        ACCUM: begin
          if (prod_valid) begin
            sum <= add_sum_c;
            cnt <= cnt - LEN_W'(1);
            if (add_ovf_c) begin
              overflow <= 1'b1;
            end
            if (cnt == LEN_W'(1)) begin
              acc_out   <= add_sum_c;
              acc_valid <= 1'b1;
              state     <= DONE;
            end
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_product_accumulator.sv
// Scoreboard bench for product_accumulator at ACC_W=64; honours PRODUCT_ACC_SAT_EN.
module tb_product_accumulator;

  localparam int unsigned ACC_W = 64;
  localparam int unsigned LEN_W = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [LEN_W-1:0]  len;
  logic [63:0]       prod_in;
  logic              prod_valid;
  logic [ACC_W-1:0]  acc_out;
  logic              acc_valid;
  logic              busy;
  logic              overflow;

  product_accumulator #(.ACC_W(ACC_W), .LEN_W(LEN_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .len        (len),
    .prod_in    (prod_in),
    .prod_valid (prod_valid),
    .acc_out    (acc_out),
    .acc_valid  (acc_valid),
    .busy       (busy),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] acc;
    logic        ovf;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [63:0] pv[$];
  int          vectors     = 0;
  int          miscompares = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every acc_valid strobe must match the oldest expected result.
  always @(negedge clk) begin
    if (acc_valid === 1'b1) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_acc_valid: acc_valid=1 at cycle %0d, expected 0", cyc);
      end else begin
        mon_e = sb.pop_front();
        check("acc_out", acc_out, mon_e.acc);
        check("overflow", 64'(overflow), 64'(mon_e.ovf));
        check("valid_cycle", 64'(cyc), 64'(mon_e.cyc));
      end
    end
  end

  task automatic wait_drain(input string name);
    int budget;
    budget = 20;
    while (sb.size() != 0 && budget > 0) begin
      @(posedge clk); #1;
      budget--;
    end
    if (sb.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL %s_timeout: %0d results outstanding, expected 0", name, sb.size());
      sb.delete();
    end
    check({name, "_busy_fall"}, 64'(busy), 64'd0);
  endtask

  // Drives one run from pv[]; a gap after pv[gap_idx] also pulses a start that must be ignored.
  task automatic run(input logic [LEN_W-1:0] l, input int gap_idx, input int gap_len,
                     input logic [63:0] exp_acc, input logic exp_ovf, input string name);
    int   last;
    exp_t e;
    @(posedge clk); #1;
    start = 1'b1;
    len   = l;
    last  = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    check({name, "_busy_rise"}, 64'(busy), 64'd1);
    for (int i = 0; i < pv.size(); i++) begin
      prod_valid = 1'b1;
      prod_in    = pv[i];
      last       = cyc;
      @(posedge clk); #1;
      prod_valid = 1'b0;
      if (i == gap_idx) begin
        start   = 1'b1;
        len     = LEN_W'(1);
        prod_in = 64'hDEAD;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (gap_len - 1) begin
          @(posedge clk); #1;
        end
      end
    end
    e.acc = exp_acc;
    e.ovf = exp_ovf;
    e.cyc = last + 1;
    sb.push_back(e);
    wait_drain(name);
  endtask

  initial begin
    int   k;
    exp_t e;
    reset      = 1'b1;
    start      = 1'b0;
    len        = '0;
    prod_in    = '0;
    prod_valid = 1'b0;
    #1;
    check("reset_acc_out", acc_out, 64'd0);
    check("reset_acc_valid", 64'(acc_valid), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_overflow", 64'(overflow), 64'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // -25 + 50 + 100, back-to-back
    pv = '{64'hFFFF_FFFF_FFFF_FFE7, 64'd50, 64'd100};
    run(8'd3, -1, 0, 64'd125, 1'b0, "len3");

    // Asynchronous reset after 2 of 5 products
    @(posedge clk); #1;
    start = 1'b1;
    len   = 8'd5;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      prod_valid = 1'b1;
      prod_in    = 64'd7;
      @(posedge clk); #1;
    end
    check("midrun_busy", 64'(busy), 64'd1);
    #2 reset = 1'b1;
    #1;
    check("midrun_reset_acc_out", acc_out, 64'd0);
    check("midrun_reset_busy", 64'(busy), 64'd0);
    check("midrun_reset_overflow", 64'(overflow), 64'd0);
    @(posedge clk); #1;
    reset      = 1'b0;
    prod_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check("midrun_idle_busy", 64'(busy), 64'd0);

    // 600 - 900 + 0 + 10000 with a 2-cycle gap after the second product
    pv = '{64'd600, 64'hFFFF_FFFF_FFFF_FC7C, 64'd0, 64'd10000};
    run(8'd4, 1, 2, 64'd9700, 1'b0, "len4_gap");

    // len=0, with a second start while busy
    @(posedge clk); #1;
    start = 1'b1;
    len   = '0;
    k     = cyc;
    @(posedge clk); #1;
    e.acc = 64'd0;
    e.ovf = 1'b0;
    e.cyc = k + 1;
    sb.push_back(e);
    check("len0_busy", 64'(busy), 64'd1);
    len = 8'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("len0_single_valid", 64'(sb.size()), 64'd0);
    check("len0_busy_after", 64'(busy), 64'd0);

`ifdef PRODUCT_ACC_SAT_EN
    pv = '{64'h4000_0000_0000_0000, 64'h4000_0000_0000_0000};
    run(8'd2, -1, 0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, "pos_ovf");
    pv = '{64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF};
    run(8'd2, -1, 0, 64'h8000_0000_0000_0000, 1'b1, "neg_ovf");
    pv = '{64'h4000_0000_0000_0000, 64'h4000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF};
    run(8'd3, -1, 0, 64'h7FFF_FFFF_FFFF_FFFE, 1'b1, "ovf_continue");
`else
    pv = '{64'h4000_0000_0000_0000, 64'h4000_0000_0000_0000};
    run(8'd2, -1, 0, 64'h8000_0000_0000_0000, 1'b1, "pos_ovf");
    pv = '{64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF};
    run(8'd2, -1, 0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, "neg_ovf");
    pv = '{64'h4000_0000_0000_0000, 64'h4000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF};
    run(8'd3, -1, 0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, "ovf_continue");
`endif

    // Overflow is per run
    pv = '{64'd1, 64'd1};
    run(8'd2, -1, 0, 64'd2, 1'b0, "after_ovf");

    // Maximum length: 1 + 2 + ... + 255
    pv.delete();
    for (int i = 1; i <= 255; i++) pv.push_back(64'(i));
    run(8'd255, -1, 0, 64'd32640, 1'b0, "len255");

    repeat (4) @(posedge clk);
    #1;
    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/product_accumulator.md
# product_accumulator

Signed accumulator that sits directly downstream of the registered 32x32 signed multiplier. It consumes its 64-bit product stream and sums a programmed number of products into a wide accumulator. It presents the sum with a one-cycle valid strobe and tracks overflow. Together the two blocks form the dot-product / MAC path.

## Interface
- ACC_W, 72, accumulator and result width in bits; legal range ACC_W >= 64.
- LEN_W, 8, width of the product-count field. A run sums at most 2^LEN_W-1 products.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle pulse that begins a run. Honoured only in IDLE.
- len  input  LEN_W  number of products in the run. Sampled with start.
- prod_in  input  64  signed product from the multiplier.
- prod_valid  input  1  prod_in is valid this cycle.
- acc_out  output  ACC_W  signed sum. Held until the next run completes.
- acc_valid  output  1  one-cycle strobe: acc_out is updated.
- busy  output  1  high in ACCUM and DONE.
- overflow  output  1  sticky per run: the signed range was exceeded during the run.

## Operation
- States: IDLE, ACCUM, DONE.
- IDLE with start=1 and len!=0:
  - latch len into cnt;
  - clear the internal sum and overflow;
  - go to ACCUM.
- IDLE with start=1 and len=0:
  - go directly to DONE with a sum of 0;
  - overflow is cleared.
- ACCUM, each cycle with prod_valid=1:
  - sign-extend prod_in to ACC_W+1 bits and add it to the sum;
  - decrement cnt.
- ACCUM with prod_valid=0: hold; no timeout.
- When the product that takes cnt to 0 is accepted, go to DONE.
- DONE, one cycle:
  - acc_out <= sum;
  - acc_valid=1;
  - return to IDLE.
- start while busy is ignored. It is neither queued nor restarts the run.
- prod_valid outside ACCUM is ignored.
- Overflow test: on each add, the (ACC_W+1)-bit result lies outside [-2^(ACC_W-1), 2^(ACC_W-1)-1].
  - On overflow, set overflow. It stays set until the next start.
  - Overflow behaviour of the stored sum is selected under Configuration.
- Reset mid-run aborts the run immediately. Every register returns to its reset value.

## Timing
- Reset values: state=IDLE, cnt=0, internal sum=0, acc_out=0, acc_valid=0, busy=0, overflow=0.
- busy rises the cycle after start is sampled.
- A run of N products with prod_valid held high completes in N+1 cycles after start:
  - N cycles in ACCUM;
  - 1 cycle in DONE.
- acc_valid and the new acc_out appear the cycle after the last product is sampled.
- busy falls the cycle after acc_valid.
- A new start is accepted in the cycle busy is low. The earliest next start is the cycle after acc_valid.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Configuration
- PRODUCT_ACC_SAT_EN
  - Defined: on overflow the sum clamps to 2^(ACC_W-1)-1 (positive) or -2^(ACC_W-1) (negative). Later adds continue from the clamped value.
  - Undefined: the sum wraps modulo 2^ACC_W (two's complement).
- overflow is flagged identically in both builds.

## Structure
- Shared package mult_pkg:
  - PROD_W=64;
  - the acc_state_t enum {IDLE, ACCUM, DONE};
  - functions or constants for the signed max/min of a given width.
- One sub-module, sat_add:
  - combinational (ACC_W+1)-bit add with overflow detect;
  - clamp logic compiled under PRODUCT_ACC_SAT_EN.
- The FSM, counter and output registers stay in product_accumulator.

## Test plan
- Reset during an ACCUM run after 2 of 5 products: all outputs read 0 immediately (asynchronous). No acc_valid follows. The next start runs cleanly.
- start, len=3, products -25, 50, 100 back-to-back: acc_valid exactly 4 cycles after start, acc_out=125, overflow=0.
- start, len=4, products 600, -900, 0, 10000 with a 2-cycle prod_valid gap after the second product: acc_out=9700. acc_valid fires one cycle after the fourth product.
- start, len=0: acc_valid the cycle after start with acc_out=0. start pulsed again while busy is ignored, producing a single acc_valid.
- ACC_W=64, len=2, products 2^62 and 2^62:
  - with PRODUCT_ACC_SAT_EN: acc_out=2^63-1, overflow=1;
  - without it: acc_out=-2^63, overflow=1.
  - A following run of 1, 1 gives 2 with overflow=0.
